// File: rtl/panda_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one-outstanding imem requests
// and buffers returned words with their PCs for decode; redirects flush and drop stale data.
module panda_fetch_ctrl #(
    parameter int unsigned      Width   = 32,
    parameter logic [Width-1:0] ResetPc = 32'h0000_0000,
    parameter int unsigned      Depth   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             redirect_i,
    input  logic [Width-1:0] redirect_target_i,
    output logic             imem_req_o,
    output logic [Width-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic [Width-1:0] instr_pc_o
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW    = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e           state_r, state_s;
    logic [Width-1:0] fetch_pc_r, fetch_pc_s;
    logic [Width-1:0] req_addr_r, req_addr_s;
    logic [Width-1:0] target_s, next_pc_s;
    logic             drop_r, drop_s;
    logic [CntW-1:0]  count_r, count_s;
    logic [PtrW-1:0]  rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
    logic [31:0]      data_mem_r [Depth];
    logic [Width-1:0] pc_mem_r [Depth];
    logic             push_s, pop_s;
    logic             unused_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == LastPtr) begin
            return {PtrW{1'b0}};
        end else begin
            return ptr + PtrW'(1'b1);
        end
    endfunction

    assign unused_s  = ^redirect_target_i[1:0];
    assign target_s  = {redirect_target_i[Width-1:2], 2'b00};
    assign next_pc_s = redirect_i ? target_s : fetch_pc_r;

    // FIFO bookkeeping: a redirect flushes and suppresses both push and pop
    always_comb begin
        push_s   = 1'b0;
        pop_s    = 1'b0;
        count_s  = count_r;
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        if ((state_r == WAIT) && imem_rvalid_i && !drop_r && !redirect_i) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if ((count_r != {CntW{1'b0}}) && instr_ready_i && !redirect_i) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (redirect_i) begin
            count_s  = {CntW{1'b0}};
            rd_ptr_s = {PtrW{1'b0}};
            wr_ptr_s = {PtrW{1'b0}};
        end else begin
            count_s  = count_r + CntW'(push_s) - CntW'(pop_s);
            rd_ptr_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            wr_ptr_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        end
    end

    // Fetch FSM next-state, PC and drop-flag logic
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = next_pc_s;
        req_addr_s = req_addr_r;
        drop_s     = drop_r;
        case (state_r)
            IDLE: begin
                if (redirect_i || (count_r < DepthC)) begin
                    state_s    = REQ;
                    req_addr_s = next_pc_s;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                drop_s = redirect_i ? 1'b1 : drop_r;
                if (imem_gnt_i) begin
                    state_s = WAIT;
                    // a grant for an already-stale request must not advance the new PC
                    if (!redirect_i && !drop_r) begin
                        fetch_pc_s = fetch_pc_r + Width'(32'd4);
                    end else begin
                        fetch_pc_s = next_pc_s;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    drop_s = 1'b0;
                    if (count_s < DepthC) begin
                        state_s    = REQ;
                        req_addr_s = next_pc_s;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    drop_s  = redirect_i ? 1'b1 : drop_r;
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                drop_s  = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            fetch_pc_r <= ResetPc;
            req_addr_r <= ResetPc;
            drop_r     <= 1'b0;
            count_r    <= {CntW{1'b0}};
            rd_ptr_r   <= {PtrW{1'b0}};
            wr_ptr_r   <= {PtrW{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            req_addr_r <= req_addr_s;
            drop_r     <= drop_s;
            count_r    <= count_s;
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
        end
    end

    // Buffer storage; contents are only meaningful while counted valid
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata_i;
            pc_mem_r[wr_ptr_r]   <= req_addr_r;
        end
    end

    assign imem_req_o    = (state_r == REQ);
    assign imem_addr_o   = req_addr_r;
    assign instr_valid_o = (count_r != {CntW{1'b0}});
    assign instr_o       = data_mem_r[rd_ptr_r];
    assign instr_pc_o    = pc_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_panda_fetch_ctrl.sv
// Bench for panda_fetch_ctrl: directed scenarios plus randomized memory/decode/redirect
// traffic checked against a delivered-instruction-stream model.
module tb_panda_fetch_ctrl;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect, gnt, rvalid, ready;
    logic [31:0] target, rdata;
    logic        req, valid;
    logic [31:0] addr, instr, pc;

    logic        req2, gnt2, rv2, unused_valid2;
    logic [31:0] addr2, unused_instr2, unused_pc2;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          pops = 0;
    logic        pend;
    logic [31:0] pend_addr, exp_pc;
    bit          rnd, gnt_en, rv_en;

    always #5 clk = ~clk;

    panda_fetch_ctrl #(.Width(32), .ResetPc(32'h0000_0000), .Depth(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .redirect_i(redirect), .redirect_target_i(target),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .instr_valid_o(valid), .instr_ready_i(ready),
        .instr_o(instr), .instr_pc_o(pc)
    );

    panda_fetch_ctrl #(.Width(32), .ResetPc(32'hFFFF_FFFC), .Depth(2)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_ni), .redirect_i(1'b0), .redirect_target_i(32'h0000_0000),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2), .imem_rvalid_i(rv2),
        .imem_rdata_i(32'h0000_0000), .instr_valid_o(unused_valid2), .instr_ready_i(1'b1),
        .instr_o(unused_instr2), .instr_pc_o(unused_pc2)
    );

    assign gnt2 = req2;

    // zero-wait memory for the wrap instance: respond the cycle after each grant
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) rv2 <= 1'b0;
        else         rv2 <= req2 && gnt2;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: drive memory/decode, then score the edge against the stream model
    task automatic tick();
        logic        p_req, p_gnt, p_rv, p_valid, p_ready, p_redir;
        logic [31:0] p_addr, p_pc, p_instr, p_tgt;
        if (rnd) begin
            ready    = ($urandom_range(0, 2) != 0);
            redirect = ($urandom_range(0, 24) == 0);
            target   = $urandom();
            gnt      = req && !pend && ($urandom_range(0, 3) != 0);
            rvalid   = pend && ($urandom_range(0, 2) != 0);
        end else begin
            gnt    = req && !pend && gnt_en;
            rvalid = pend && rv_en;
        end
        rdata = rvalid ? (pend_addr ^ KEY) : 32'hDEAD_BEEF;
        p_req = req; p_gnt = gnt; p_rv = rvalid; p_valid = valid; p_ready = ready;
        p_redir = redirect; p_addr = addr; p_pc = pc; p_instr = instr; p_tgt = target;
        @(posedge clk);
        #1;
        if (p_gnt) begin
            pend      = 1'b1;
            pend_addr = p_addr;
        end
        if (p_rv) pend = 1'b0;
        if (p_redir) begin
            exp_pc = p_tgt & 32'hFFFF_FFFC;
            check_eq("flush_valid", 32'(valid), 32'd0);
        end else if (p_valid && p_ready) begin
            check_eq("pop_pc", p_pc, exp_pc);
            check_eq("pop_instr", p_instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (p_req && !p_gnt) begin
            check_eq("req_hold", 32'(req), 32'd1);
            check_eq("addr_hold", addr, p_addr);
        end
        check_eq("one_outstanding", 32'(req && pend), 32'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        redirect = 1'b0; target = 32'd0; ready = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        pend = 1'b0; pend_addr = 32'd0; exp_pc = 32'd0;
        rnd = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_addr", addr, 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
        rst_ni = 1'b1;
    endtask

    initial begin
        // zero-wait streaming, plus wrap of the fetch PC in the second instance
        do_reset();
        ready = 1'b1;
        tick();
        check_eq("boot_req", 32'(req), 32'd1);
        check_eq("boot_addr", addr, 32'd0);
        check_eq("wrap_addr0", addr2, 32'hFFFF_FFFC);
        tick();
        check_eq("wait_req", 32'(req), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("stream_valid", 32'(valid), 32'((i % 2) == 0));
            if ((i % 2) == 0) begin
                check_eq("stream_pc", pc, 32'(4 * (i / 2)));
                check_eq("stream_instr", instr, 32'(4 * (i / 2)) ^ KEY);
            end
            if (i == 0) check_eq("wrap_addr1", addr2, 32'h0000_0000);
        end

        // back-pressure: buffer fills, requests stop, then resume after draining
        do_reset();
        ready = 1'b0;
        repeat (8) tick();
        check_eq("full_req", 32'(req), 32'd0);
        check_eq("full_valid", 32'(valid), 32'd1);
        check_eq("full_pc", pc, 32'h0);
        ready = 1'b1;
        tick();
        check_eq("drain_pc", pc, 32'h4);
        check_eq("drain_req", 32'(req), 32'd0);
        tick();
        check_eq("refill_req", 32'(req), 32'd1);
        check_eq("refill_addr", addr, 32'h8);

        // redirect while waiting for the response of 0x8
        do_reset();
        ready = 1'b1;
        repeat (5) tick();
        check_eq("pre_redir_pc", pc, 32'h4);
        ready = 1'b0;
        tick();
        check_eq("wait8_req", 32'(req), 32'd0);
        rv_en = 1'b0; redirect = 1'b1; target = 32'h100;
        tick();
        redirect = 1'b0; rv_en = 1'b1; ready = 1'b1;
        tick();
        check_eq("redir_req", 32'(req), 32'd1);
        check_eq("redir_addr", addr, 32'h100);
        check_eq("drop_valid", 32'(valid), 32'd0);
        repeat (2) tick();
        check_eq("redir_pc", pc, 32'h100);
        check_eq("redir_instr", instr, 32'h100 ^ KEY);

        // ungranted request for 0xC with a redirect in the middle of the stall
        do_reset();
        ready = 1'b1;
        repeat (7) tick();
        check_eq("stall_start_addr", addr, 32'hC);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            redirect = (i == 1);
            target   = 32'h200;
            tick();
            redirect = 1'b0;
            check_eq("stall_req", 32'(req), 32'd1);
            check_eq("stall_addr", addr, 32'hC);
        end
        gnt_en = 1'b1;
        tick();
        check_eq("stale_wait", 32'(req), 32'd0);
        tick();
        check_eq("post_stall_addr", addr, 32'h200);
        check_eq("post_stall_valid", 32'(valid), 32'd0);
        repeat (2) tick();
        check_eq("post_stall_pc", pc, 32'h200);

        // redirect coinciding with both a response and a pop
        ready = 1'b0;
        tick();
        check_eq("coinc_wait", 32'(req), 32'd0);
        ready = 1'b1; redirect = 1'b1; target = 32'h300;
        tick();
        redirect = 1'b0;
        check_eq("coinc_valid", 32'(valid), 32'd0);
        check_eq("coinc_addr", addr, 32'h300);
        repeat (2) tick();
        check_eq("coinc_pc", pc, 32'h300);

        // unaligned redirect target while idle
        do_reset();
        ready = 1'b1; redirect = 1'b1; target = 32'h103;
        tick();
        redirect = 1'b0;
        check_eq("align_req", 32'(req), 32'd1);
        check_eq("align_addr", addr, 32'h100);
        repeat (2) tick();
        check_eq("align_pc", pc, 32'h100);

        // randomized traffic
        do_reset();
        rnd = 1'b1;
        pops = 0;
        repeat (3000) tick();
        check_eq("liveness", 32'(pops > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
